// File: rtl/dfa_pattern_detector.sv
`timescale 1ns/1ps
// dfa_pattern_detector
//   Serial bit-pattern recogniser. The state is the length of the longest
//   prefix of PATTERN that is a suffix of the consumed bits. Transitions are
//   derived from PATTERN at elaboration by constant functions.
//   Optional macro DFA_MATCH_COUNT_EN adds a saturating match counter. Without
//   it, match_count and count_sat are tied low.
// Ports
//   clk            : clock, rising edge
//   reset          : synchronous, active-high reset
//   in_valid       : qualifies input_sequence
//   input_sequence : serial data bit
//   overlap        : 1 = overlapping matches, 0 = restart after each match
//   match          : registered one-cycle match strobe
//   match_count    : saturating number of matches since reset
//   count_sat      : high once match_count has reached all-ones
module dfa_pattern_detector #(
  parameter int unsigned              PATTERN_LEN = 2,
  parameter logic [PATTERN_LEN-1:0]   PATTERN     = 2'b01,
  parameter int unsigned              COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               input_sequence,
  input  logic               overlap,
  output logic               match,
  output logic [COUNT_W-1:0] match_count,
  output logic               count_sat
);

  localparam int unsigned SW = $clog2(PATTERN_LEN + 1);
  localparam logic [31:0] PAT32 = 32'(PATTERN);

  // Bit k of the pattern in arrival order (k = 0 is the first bit received).
  function automatic logic pat_bit(input int unsigned k);
    return PAT32[5'(PATTERN_LEN - 1 - k)];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length s) followed by b.
  function automatic int unsigned next_state(input int unsigned s, input logic b);
    logic [31:0] seq;
    int unsigned res;
    logic        ok;
    seq = '0;
    for (int unsigned i = 0; i < s; i++) seq[5'(i)] = pat_bit(i);
    seq[5'(s)] = b;
    res = 0;
    for (int unsigned k = 1; k <= s + 1; k++) begin
      if (k <= PATTERN_LEN) begin
        ok = 1'b1;
        for (int unsigned j = 0; j < k; j++)
          if (pat_bit(j) != seq[5'(s + 1 - k + j)]) ok = 1'b0;
        if (ok) res = k;
      end
    end
    return res;
  endfunction

  // Longest proper border of the full pattern: restart point for overlapping matches.
  function automatic int unsigned border_len();
    int unsigned res;
    logic        ok;
    res = 0;
    for (int unsigned k = 1; k < PATTERN_LEN; k++) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < k; j++)
        if (pat_bit(j) != pat_bit(PATTERN_LEN - k + j)) ok = 1'b0;
      if (ok) res = k;
    end
    return res;
  endfunction

  localparam int unsigned BORDER = border_len();

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] nxt_state;
  logic          match_q, match_d;

  // Next-state / match computation
  always_comb begin
    state_d   = state_q;
    match_d   = 1'b0;
    nxt_state = '0;
    if (in_valid) begin
      for (int unsigned s = 0; s < PATTERN_LEN; s++) begin
        if (state_q == SW'(s))
          nxt_state = input_sequence ? SW'(next_state(s, 1'b1)) : SW'(next_state(s, 1'b0));
      end
      if (nxt_state == SW'(PATTERN_LEN)) begin
        match_d = 1'b1;
        state_d = overlap ? SW'(BORDER) : '0;
      end else begin
        state_d = nxt_state;
      end
    end
  end

  // State and match registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

`ifdef DFA_MATCH_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;
  logic               sat_q, sat_d;

  // Saturating counter; sat flag rises with the first all-ones value.
  always_comb begin
    count_d = count_q;
    if (match_d && (count_q != '1)) count_d = count_q + COUNT_W'(1);
    sat_d = sat_q | (count_d == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match_count = count_q;
  assign count_sat   = sat_q;
`else
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_dfa_pattern_detector.sv
`timescale 1ns/1ps
// Bench for dfa_pattern_detector: three instances (01/COUNT_W=8, 101/COUNT_W=8,
// 01/COUNT_W=2) share one stimulus stream and are checked against a
// history-based reference model through an expected-value queue.
module tb_dfa_pattern_detector;

`ifdef DFA_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_valid, input_sequence, overlap;
  logic       m0, m1, m2, s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  dfa_pattern_detector #(.PATTERN_LEN(2), .PATTERN(2'b01), .COUNT_W(8)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_sequence(input_sequence),
    .overlap(overlap), .match(m0), .match_count(c0), .count_sat(s0));
  dfa_pattern_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .COUNT_W(8)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_sequence(input_sequence),
    .overlap(overlap), .match(m1), .match_count(c1), .count_sat(s1));
  dfa_pattern_detector #(.PATTERN_LEN(2), .PATTERN(2'b01), .COUNT_W(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_sequence(input_sequence),
    .overlap(overlap), .match(m2), .match_count(c2), .count_sat(s2));

  typedef struct packed {
    logic [2:0] m;
    logic [7:0] c0;
    logic [7:0] c1;
    logic [1:0] c2;
    logic [2:0] s;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned plen[3] = '{2, 3, 2};
  logic [31:0] pat[3]  = '{32'b01, 32'b101, 32'b01};
  int unsigned cap[3]  = '{255, 255, 3};
  logic [31:0] hist[3];
  int unsigned avail[3];
  int unsigned cnt[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic b, input logic ov);
    exp_t        e;
    logic [2:0]  mt;
    logic [2:0]  st;
    logic [31:0] mask;
    int unsigned ec[3];
    @(negedge clk);
    reset = r; in_valid = v; input_sequence = b; overlap = ov;
    mt = '0;
    st = '0;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        hist[i] = '0; avail[i] = 0; cnt[i] = 0;
      end else if (v) begin
        hist[i] = {hist[i][30:0], b};
        if (avail[i] < 32) avail[i]++;
        mask = (32'd1 << plen[i]) - 32'd1;
        if (avail[i] >= plen[i] && (hist[i] & mask) == pat[i]) begin
          mt[i] = 1'b1;
          if (!ov) avail[i] = 0;
          if (cnt[i] < cap[i]) cnt[i]++;
        end
      end
      st[i] = CNT_EN && (cnt[i] == cap[i]);
      ec[i] = CNT_EN ? cnt[i] : 0;
    end
    e.m = mt; e.s = st;
    e.c0 = 8'(ec[0]); e.c1 = 8'(ec[1]); e.c2 = 2'(ec[2]);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("match0", 32'(m0), 32'(e.m[0]));
    check("match1", 32'(m1), 32'(e.m[1]));
    check("match2", 32'(m2), 32'(e.m[2]));
    check("count0", 32'(c0), 32'(e.c0));
    check("count1", 32'(c1), 32'(e.c1));
    check("count2", 32'(c2), 32'(e.c2));
    check("sat0", 32'(s0), 32'(e.s[0]));
    check("sat1", 32'(s1), 32'(e.s[1]));
    check("sat2", 32'(s2), 32'(e.s[2]));
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], ov);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; input_sequence = 1'b0; overlap = 1'b1;

    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);   // reset wins over a valid bit

    // 0,0,1,0,1,1,0,0,1 with overlap: matches after bits 3, 5 and 9
    send_bits(32'b001011001, 9, 1'b1);
    check("t1_count", 32'(c0), CNT_EN ? 32'd3 : 32'd0);

    // 101 stream 1,0,1,0,1 overlapping, then non-overlapping
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(32'b10101, 5, 1'b1);
    check("t2_count", 32'(c1), CNT_EN ? 32'd2 : 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(32'b10101, 5, 1'b0);
    check("t3_count", 32'(c1), CNT_EN ? 32'd1 : 32'd0);

    // Gap transparency: valid 0, four invalid 1s, valid 1
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t4_match", 32'(m0), 32'd1);

    // Saturation of the 2-bit counter over five matches
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bits(32'b01, 2, 1'b1);
    check("t5_count", 32'(c2), CNT_EN ? 32'd3 : 32'd0);
    check("t5_sat", 32'(s2), CNT_EN ? 32'd1 : 32'd0);

    // Reset discards a partial prefix
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("t6_nomatch", 32'(m0), 32'd0);
    send_bits(32'b01, 2, 1'b1);
    check("t6_count", 32'(c0), CNT_EN ? 32'd1 : 32'd0);

    // Random traffic with occasional resets and overlap changes
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
